// File: rtl/sgpr_busy_table_ctrl.sv
// -----------------------------------------------------------------------------
// sgpr_busy_table_ctrl
//
// Purpose:
//   Scalar register busy table for one wavefront slot. Issue-time reservations
//   (set) are merged with SALU (clr0) and LSU (clr1) writeback releases. Each
//   cycle the table is updated as
//      next = (table & ~clr0 & ~clr1 & ~flush_chunk) | set.
//   Readiness queries are answered one cycle later from the next-state table.
//   A wavefront retire triggers a multi-cycle flush that clears FLUSH_CHUNK
//   bits per cycle. Every port uses a base+word-mask decode in which word i
//   selects register (addr+i) mod NUMBER_SGPR, so accesses wrap at the top.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   set_valid/set_addr/set_mask     reservation; accepted when set_ready=1
//   set_ready                       low while a flush is running
//   clr0_valid/clr0_addr/clr0_mask  SALU release, always accepted
//   clr1_valid/clr1_addr/clr1_mask  LSU release, always accepted
//   chk_valid/chk_addr/chk_mask     readiness query
//   chk_resp_valid/chk_busy         query response, 1-cycle latency
//   flush_req                       pulse; clear the whole table
//   flush_busy                      flush in progress
//   table_empty                     registered; no table bit set
//
// Optional build macro SGPR_BUSY_ERR_CHK_EN adds:
//   err       sticky; double reservation or release of a free register
//   err_addr  base address of the first offending operation
// -----------------------------------------------------------------------------
module sgpr_busy_table_ctrl #(
   parameter int NUMBER_SGPR      = 512,
   parameter int SGPR_ADDR_LENGTH = 9,
   parameter int MAX_NUMBER_WORDS = 4,
   parameter int FLUSH_CHUNK      = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        set_valid,
   input  logic [SGPR_ADDR_LENGTH-1:0] set_addr,
   input  logic [MAX_NUMBER_WORDS-1:0] set_mask,
   output logic                        set_ready,
   input  logic                        clr0_valid,
   input  logic [SGPR_ADDR_LENGTH-1:0] clr0_addr,
   input  logic [MAX_NUMBER_WORDS-1:0] clr0_mask,
   input  logic                        clr1_valid,
   input  logic [SGPR_ADDR_LENGTH-1:0] clr1_addr,
   input  logic [MAX_NUMBER_WORDS-1:0] clr1_mask,
   input  logic                        chk_valid,
   input  logic [SGPR_ADDR_LENGTH-1:0] chk_addr,
   input  logic [MAX_NUMBER_WORDS-1:0] chk_mask,
   output logic                        chk_resp_valid,
   output logic                        chk_busy,
   input  logic                        flush_req,
   output logic                        flush_busy,
   output logic                        table_empty
`ifdef SGPR_BUSY_ERR_CHK_EN
   ,
   output logic                        err,
   output logic [SGPR_ADDR_LENGTH-1:0] err_addr
`endif
);

   localparam int NUM_CHUNKS = NUMBER_SGPR / FLUSH_CHUNK;
   localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic {IDLE, FLUSH} state_t;

   // Base+mask decode. The index is computed in SGPR_ADDR_LENGTH bits, so
   // the natural overflow of the sum provides the wrap-around.
   function automatic logic [NUMBER_SGPR-1:0] decode(
      input logic [SGPR_ADDR_LENGTH-1:0] addr,
      input logic [MAX_NUMBER_WORDS-1:0] mask
   );
      logic [NUMBER_SGPR-1:0]      bits;
      logic [SGPR_ADDR_LENGTH-1:0] idx;
      bits = '0;
      for (int i = 0; i < MAX_NUMBER_WORDS; i++) begin
         idx = addr + SGPR_ADDR_LENGTH'(i);
         if (mask[i]) bits[idx] = 1'b1;
      end
      return bits;
   endfunction

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUMBER_SGPR-1:0] table_q, table_d;
   logic                   set_ready_q, set_ready_d;
   logic                   flush_busy_q, flush_busy_d;
   logic                   chk_resp_valid_q, chk_resp_valid_d;
   logic                   chk_busy_q, chk_busy_d;
   logic                   table_empty_q, table_empty_d;

   logic                   set_acc;
   logic [NUMBER_SGPR-1:0] set_bits, clr0_bits, clr1_bits, chk_bits, flush_bits;

   // Flush mask: the chunk addressed by the counter, only while flushing.
   genvar gi;
   generate
      for (gi = 0; gi < NUMBER_SGPR; gi++) begin : g_flush
         assign flush_bits[gi] = (state_q == FLUSH) && (cnt_q == CNT_W'(gi / FLUSH_CHUNK));
      end
   endgenerate

   always_comb begin
      set_acc   = set_valid & set_ready_q;
      set_bits  = set_acc    ? decode(set_addr,  set_mask)  : '0;
      clr0_bits = clr0_valid ? decode(clr0_addr, clr0_mask) : '0;
      clr1_bits = clr1_valid ? decode(clr1_addr, clr1_mask) : '0;
      chk_bits  = decode(chk_addr, chk_mask);

      // Set is OR-ed last so it wins over a same-cycle clear of the same bit.
      table_d = (table_q & ~clr0_bits & ~clr1_bits & ~flush_bits) | set_bits;

      // Queries see the next-state table so same-cycle updates are visible.
      chk_resp_valid_d = chk_valid;
      chk_busy_d       = chk_valid & (|(table_d & chk_bits));
      table_empty_d    = ~(|table_d);

      state_d      = state_q;
      cnt_d        = cnt_q;
      set_ready_d  = set_ready_q;
      flush_busy_d = flush_busy_q;
      case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d      = FLUSH;
               cnt_d        = '0;
               set_ready_d  = 1'b0;
               flush_busy_d = 1'b1;
            end
         end
         FLUSH: begin
            // flush_req is deliberately ignored here: a second retire request
            // during a flush has nothing left to add.
            if (cnt_q == LAST_CHUNK) begin
               state_d      = IDLE;
               cnt_d        = '0;
               set_ready_d  = 1'b1;
               flush_busy_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d      = IDLE;
            cnt_d        = '0;
            set_ready_d  = 1'b1;
            flush_busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         table_q          <= '0;
         set_ready_q      <= 1'b1;
         flush_busy_q     <= 1'b0;
         chk_resp_valid_q <= 1'b0;
         chk_busy_q       <= 1'b0;
         table_empty_q    <= 1'b1;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         table_q          <= table_d;
         set_ready_q      <= set_ready_d;
         flush_busy_q     <= flush_busy_d;
         chk_resp_valid_q <= chk_resp_valid_d;
         chk_busy_q       <= chk_busy_d;
         table_empty_q    <= table_empty_d;
      end
   end

   assign set_ready      = set_ready_q;
   assign flush_busy     = flush_busy_q;
   assign chk_resp_valid = chk_resp_valid_q;
   assign chk_busy       = chk_busy_q;
   assign table_empty    = table_empty_q;

`ifdef SGPR_BUSY_ERR_CHK_EN
   logic                        err_q, err_d;
   logic [SGPR_ADDR_LENGTH-1:0] err_addr_q, err_addr_d;
   logic                        set_err, clr0_err, clr1_err;

   always_comb begin
      // A set onto a busy bit is fine only if that bit is being released now.
      set_err  = set_acc && (|(set_bits & table_q & ~clr0_bits & ~clr1_bits));
      // Releases during a flush race with the chunk clears, so skip them.
      clr0_err = (state_q != FLUSH) && (|(clr0_bits & ~table_q));
      clr1_err = (state_q != FLUSH) && (|(clr1_bits & ~table_q));

      err_d      = err_q | set_err | clr0_err | clr1_err;
      err_addr_d = err_addr_q;
      if (!err_q) begin
         if (set_err)       err_addr_d = set_addr;
         else if (clr0_err) err_addr_d = clr0_addr;
         else if (clr1_err) err_addr_d = clr1_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err      = err_q;
   assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_sgpr_busy_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sgpr_busy_table_ctrl
//
// Directed bench for sgpr_busy_table_ctrl: a table of single-cycle vectors
// (set/clear/query with hand-computed responses) followed by hand-written
// sequences for the flush, reset-during-flush and, when built with
// SGPR_BUSY_ERR_CHK_EN, the error capture.
// -----------------------------------------------------------------------------
module tb_sgpr_busy_table_ctrl;

   localparam int AW = 9;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          set_valid;
   logic [AW-1:0] set_addr;
   logic [MW-1:0] set_mask;
   logic          set_ready;
   logic          clr0_valid;
   logic [AW-1:0] clr0_addr;
   logic [MW-1:0] clr0_mask;
   logic          clr1_valid;
   logic [AW-1:0] clr1_addr;
   logic [MW-1:0] clr1_mask;
   logic          chk_valid;
   logic [AW-1:0] chk_addr;
   logic [MW-1:0] chk_mask;
   logic          chk_resp_valid;
   logic          chk_busy;
   logic          flush_req;
   logic          flush_busy;
   logic          table_empty;
`ifdef SGPR_BUSY_ERR_CHK_EN
   logic          err;
   logic [AW-1:0] err_addr;
`endif

   always #5 clk = ~clk;

   sgpr_busy_table_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .set_valid      (set_valid),
      .set_addr       (set_addr),
      .set_mask       (set_mask),
      .set_ready      (set_ready),
      .clr0_valid     (clr0_valid),
      .clr0_addr      (clr0_addr),
      .clr0_mask      (clr0_mask),
      .clr1_valid     (clr1_valid),
      .clr1_addr      (clr1_addr),
      .clr1_mask      (clr1_mask),
      .chk_valid      (chk_valid),
      .chk_addr       (chk_addr),
      .chk_mask       (chk_mask),
      .chk_resp_valid (chk_resp_valid),
      .chk_busy       (chk_busy),
      .flush_req      (flush_req),
      .flush_busy     (flush_busy),
      .table_empty    (table_empty)
`ifdef SGPR_BUSY_ERR_CHK_EN
      ,
      .err            (err),
      .err_addr       (err_addr)
`endif
   );

   typedef struct {
      logic          sv;
      logic [AW-1:0] sa;
      logic [MW-1:0] sm;
      logic          c0v;
      logic [AW-1:0] c0a;
      logic [MW-1:0] c0m;
      logic          c1v;
      logic [AW-1:0] c1a;
      logic [MW-1:0] c1m;
      logic          kv;
      logic [AW-1:0] ka;
      logic [MW-1:0] km;
      logic          e_rv;
      logic          e_busy;
      logic          e_empty;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   int checks = 0;
   int errors = 0;

   function automatic vec_t mkv(
      input logic sv,  input logic [AW-1:0] sa,  input logic [MW-1:0] sm,
      input logic c0v, input logic [AW-1:0] c0a, input logic [MW-1:0] c0m,
      input logic c1v, input logic [AW-1:0] c1a, input logic [MW-1:0] c1m,
      input logic kv,  input logic [AW-1:0] ka,  input logic [MW-1:0] km,
      input logic e_rv, input logic e_busy, input logic e_empty
   );
      vec_t v;
      v.sv = sv;   v.sa = sa;   v.sm = sm;
      v.c0v = c0v; v.c0a = c0a; v.c0m = c0m;
      v.c1v = c1v; v.c1a = c1a; v.c1m = c1m;
      v.kv = kv;   v.ka = ka;   v.km = km;
      v.e_rv = e_rv; v.e_busy = e_busy; v.e_empty = e_empty;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      set_valid = 1'b0;  set_addr = '0;  set_mask = '0;
      clr0_valid = 1'b0; clr0_addr = '0; clr0_mask = '0;
      clr1_valid = 1'b0; clr1_addr = '0; clr1_mask = '0;
      chk_valid = 1'b0;  chk_addr = '0;  chk_mask = '0;
      flush_req = 1'b0;
   endtask

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_set(input logic [AW-1:0] a, input logic [MW-1:0] m);
      set_valid = 1'b1; set_addr = a; set_mask = m;
   endtask

   task automatic do_chk(input logic [AW-1:0] a, input logic [MW-1:0] m);
      chk_valid = 1'b1; chk_addr = a; chk_mask = m;
   endtask

   // Called at posedge+1: pulse reset between edges and check reset values.
   task automatic pulse_reset(input string tag);
      #1 rst = 1'b0;
      #1;
      check({tag, "_set_ready"},  32'(set_ready), 32'd1);
      check({tag, "_flush_busy"}, 32'(flush_busy), 32'd0);
      check({tag, "_resp_valid"}, 32'(chk_resp_valid), 32'd0);
      check({tag, "_chk_busy"},   32'(chk_busy), 32'd0);
      check({tag, "_empty"},      32'(table_empty), 32'd1);
`ifdef SGPR_BUSY_ERR_CHK_EN
      check({tag, "_err"},        32'(err), 32'd0);
`endif
      #1 rst = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int fb_cycles;
      int rdy_bad;
      int n;
      logic empty_before_last;

      //             set             clr0            clr1            chk             rv busy empty
      vecs[0]  = mkv(1, 8,   4'b0011, 0, 0,  4'b0000, 0, 0,   4'b0000, 0, 0,   4'b0000, 0, 0, 0);
      vecs[1]  = mkv(0, 0,   4'b0000, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 8,   4'b0001, 1, 1, 0);
      vecs[2]  = mkv(0, 0,   4'b0000, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 10,  4'b0001, 1, 0, 0);
      vecs[3]  = mkv(0, 0,   4'b0000, 1, 8,  4'b0011, 0, 0,   4'b0000, 1, 8,   4'b0011, 1, 0, 1);
      vecs[4]  = mkv(1, 510, 4'b1111, 0, 0,  4'b0000, 0, 0,   4'b0000, 0, 0,   4'b0000, 0, 0, 0);
      vecs[5]  = mkv(0, 0,   4'b0000, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 0,   4'b0011, 1, 1, 0);
      vecs[6]  = mkv(0, 0,   4'b0000, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 2,   4'b0001, 1, 0, 0);
      vecs[7]  = mkv(0, 0,   4'b0000, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 508, 4'b0100, 1, 1, 0);
      vecs[8]  = mkv(0, 0,   4'b0000, 0, 0,  4'b0000, 1, 510, 4'b1111, 1, 0,   4'b0001, 1, 0, 1);
      vecs[9]  = mkv(1, 20,  4'b0001, 0, 0,  4'b0000, 0, 0,   4'b0000, 0, 0,   4'b0000, 0, 0, 0);
      vecs[10] = mkv(1, 20,  4'b0001, 1, 20, 4'b0001, 0, 0,   4'b0000, 1, 20,  4'b0001, 1, 1, 0);
      vecs[11] = mkv(0, 0,   4'b0000, 1, 20, 4'b0001, 1, 20,  4'b0001, 1, 20,  4'b0001, 1, 0, 1);
      vecs[12] = mkv(1, 30,  4'b0000, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 30,  4'b0001, 1, 0, 1);
      vecs[13] = mkv(0, 30,  4'b0001, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 30,  4'b0001, 1, 0, 1);
      vecs[14] = mkv(1, 31,  4'b0001, 0, 0,  4'b0000, 0, 0,   4'b0000, 1, 31,  4'b0001, 1, 1, 0);
      vecs[15] = mkv(0, 0,   4'b0000, 1, 31, 4'b0001, 0, 0,   4'b0000, 0, 0,   4'b0000, 0, 0, 1);

      clear_inputs();
      rst = 1'b0;
      #12;
      check("reset_set_ready",  32'(set_ready), 32'd1);
      check("reset_flush_busy", 32'(flush_busy), 32'd0);
      check("reset_resp_valid", 32'(chk_resp_valid), 32'd0);
      check("reset_chk_busy",   32'(chk_busy), 32'd0);
      check("reset_empty",      32'(table_empty), 32'd1);
      rst = 1'b1;
      tick();

      // ---------------- table-driven single-cycle vectors ----------------
      for (int i = 0; i < NV; i++) begin
         set_valid  = vecs[i].sv;  set_addr  = vecs[i].sa;  set_mask  = vecs[i].sm;
         clr0_valid = vecs[i].c0v; clr0_addr = vecs[i].c0a; clr0_mask = vecs[i].c0m;
         clr1_valid = vecs[i].c1v; clr1_addr = vecs[i].c1a; clr1_mask = vecs[i].c1m;
         chk_valid  = vecs[i].kv;  chk_addr  = vecs[i].ka;  chk_mask  = vecs[i].km;
         tick();
         check($sformatf("vec%0d_resp_valid", i), 32'(chk_resp_valid), 32'(vecs[i].e_rv));
         if (vecs[i].e_rv)
            check($sformatf("vec%0d_chk_busy", i), 32'(chk_busy), 32'(vecs[i].e_busy));
         check($sformatf("vec%0d_empty", i), 32'(table_empty), 32'(vecs[i].e_empty));
         check($sformatf("vec%0d_set_ready", i), 32'(set_ready), 32'd1);
         $display("vec %0d: rv=%0d busy=%0d empty=%0d", i, chk_resp_valid, chk_busy, table_empty);
         clear_inputs();
      end
`ifdef SGPR_BUSY_ERR_CHK_EN
      check("vec_no_err", 32'(err), 32'd0);
`endif

      // ---------------- flush sequence ----------------
      do_set(0, 4'b0001);   tick();
      do_set(100, 4'b0001); tick();
      do_set(511, 4'b0001); tick();
      clear_inputs();
      check("fill_empty", 32'(table_empty), 32'd0);
      // Set and flush together in IDLE: set lands, then the flush removes it.
      do_set(200, 4'b0001);
      flush_req = 1'b1;
      tick();
      clear_inputs();
      check("flush_start_busy",  32'(flush_busy), 32'd1);
      check("flush_start_ready", 32'(set_ready), 32'd0);
      check("flush_start_empty", 32'(table_empty), 32'd0);
      fb_cycles = 0;
      rdy_bad = 0;
      n = 0;
      empty_before_last = 1'b1;
      while (flush_busy === 1'b1 && n < 20) begin
         n++;
         fb_cycles++;
         if (set_ready !== 1'b0) rdy_bad++;
         if (n == 8) empty_before_last = table_empty;
         if (n == 1) begin
            do_set(300, 4'b0001);   // offered during flush: must not be taken
            do_chk(511, 4'b0001);   // chunk 7 not cleared yet
         end
         if (n == 3) flush_req = 1'b1;  // ignored during flush
         tick();
         if (n == 1) begin
            check("flush_query_valid", 32'(chk_resp_valid), 32'd1);
            check("flush_query_busy",  32'(chk_busy), 32'd1);
         end
         clear_inputs();
      end
      $display("flush: busy cycles=%0d", fb_cycles);
      check("flush_cycles",        32'(fb_cycles), 32'd8);
      check("flush_ready_low",     32'(rdy_bad), 32'd0);
      check("flush_pre_last_empty", 32'(empty_before_last), 32'd0);
      check("flush_done_busy",     32'(flush_busy), 32'd0);
      check("flush_done_ready",    32'(set_ready), 32'd1);
      check("flush_done_empty",    32'(table_empty), 32'd1);
      do_chk(300, 4'b0001); tick(); clear_inputs();
      check("flush_set_rejected", 32'(chk_busy), 32'd0);
      do_chk(200, 4'b0001); tick(); clear_inputs();
      check("flush_removed_set",  32'(chk_busy), 32'd0);
      check("flush_stays_idle",   32'(flush_busy), 32'd0);

      // ---------------- reset during flush ----------------
      do_set(300, 4'b0001); tick(); clear_inputs();
      flush_req = 1'b1; tick(); clear_inputs();   // flush cycle 1
      tick();                                     // flush cycle 2
      tick();                                     // flush cycle 3
      check("midflush_busy", 32'(flush_busy), 32'd1);
      $display("reset asserted in flush cycle 3");
      pulse_reset("midflush_rst");
      check("post_rst_no_flush", 32'(flush_busy), 32'd0);
      do_set(40, 4'b0001); tick(); clear_inputs();
      check("post_rst_empty", 32'(table_empty), 32'd0);
      do_chk(40, 4'b0001); tick(); clear_inputs();
      check("post_rst_resp_valid", 32'(chk_resp_valid), 32'd1);
      check("post_rst_busy",       32'(chk_busy), 32'd1);
      tick(); tick();
      check("post_rst_still_idle", 32'(flush_busy), 32'd0);
      check("post_rst_ready",      32'(set_ready), 32'd1);

`ifdef SGPR_BUSY_ERR_CHK_EN
      // ---------------- error capture ----------------
      pulse_reset("err_rst");
      clr1_valid = 1'b1; clr1_addr = 40; clr1_mask = 4'b0001;
      tick(); clear_inputs();
      check("err_set",  32'(err), 32'd1);
      check("err_addr", 32'(err_addr), 32'd40);
      clr0_valid = 1'b1; clr0_addr = 50; clr0_mask = 4'b0001;
      tick(); clear_inputs();
      tick();
      check("err_sticky",     32'(err), 32'd1);
      check("err_addr_first", 32'(err_addr), 32'd40);
      $display("err captured at address %0d", err_addr);
      pulse_reset("err_clear");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
